mem_arbiter: RTL

Two-requester arbiter that shares one `Memory` bus between the core's instruction-fetch port and data port. It sits between the fetch/LSU masters and the memory slave, registers the winning request onto the shared bus, and routes each load response back to the requester that issued it. A small in-order tag FIFO tracks the routing.

---
 rtl/mem_arbiter_if.sv | 25 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Memory bus: valid/ready request channel (m_*) from master to slave and a
// valid/ready response channel (s_*) from slave back to master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_data;
    logic              m_write;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output m_address, m_data, m_write, m_valid, s_ready,
        input  m_ready, s_data, s_valid
    );

    modport slave (
        input  m_address, m_data, m_write, m_valid, s_ready,
        output m_ready, s_data, s_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory bus between the
// instruction-fetch requester (req0) and the data requester (req1). The
// winning request is registered onto the bus; load responses are routed back
// to their issuer through an in-order tag FIFO holding the requester id.
module mem_arbiter #(
    parameter int TAG_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  req0,
    mem_arbiter_if.slave  req1,
    mem_arbiter_if.master mem,
    output logic          err
);

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(TAG_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TAG_DEPTH);

    // Arbitration
    logic              slot;
    logic              elig0;
    logic              elig1;
    logic              grant;
    logic              accept0;
    logic              accept1;

    // Registered bus request and round-robin pointer
    logic [ADDR_W-1:0] m_address_q, m_address_d;
    logic [DATA_W-1:0] m_data_q,    m_data_d;
    logic              m_write_q,   m_write_d;
    logic              m_valid_q,   m_valid_d;
    logic              prio_q,      prio_d;

    // Tag FIFO: one bit per outstanding load, 0 = req0, 1 = req1
    logic              tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              push;
    logic              push_id;
    logic              pop;
    logic              head;
    logic              tags_pending;
    logic              err_q, err_d;

    // Eligibility, round-robin grant and the request-side handshake.
    always_comb begin
        // NOTE: every signal written here is assigned on all paths, so no latch is inferred.
        slot  = !m_valid_q || mem.m_ready;
        elig0 = req0.m_valid && (req0.m_write || (count_q < DEPTH_C));
        elig1 = req1.m_valid && (req1.m_write || (count_q < DEPTH_C));
        grant = prio_q;
        if (elig0 && !elig1) begin
            grant = 1'b0;
        end else if (elig1 && !elig0) begin
            grant = 1'b1;
        end
        accept0 = slot && !grant && elig0;
        accept1 = slot &&  grant && elig1;
    end

    assign req0.m_ready = accept0;
    assign req1.m_ready = accept1;

    // Response routing is a pure pass-through steered by the FIFO head.
    assign tags_pending = (count_q != '0);
    assign head         = tag_mem_q[rd_ptr_q];
    assign mem.s_ready  = tags_pending ? (head ? req1.s_ready : req0.s_ready) : 1'b1;
    assign req0.s_valid = mem.s_valid && tags_pending && !head;
    assign req1.s_valid = mem.s_valid && tags_pending &&  head;
    assign req0.s_data  = mem.s_data;
    assign req1.s_data  = mem.s_data;

    // Bus output register drives the shared bus directly.
    assign mem.m_address = m_address_q;
    assign mem.m_data    = m_data_q;
    assign mem.m_write   = m_write_q;
    assign mem.m_valid   = m_valid_q;
    assign err           = err_q;

    // Next state for the bus register, priority pointer, tag FIFO and error flag.
    always_comb begin
        m_address_d = m_address_q;
        m_data_d    = m_data_q;
        m_write_d   = m_write_q;
        m_valid_d   = m_valid_q;
        prio_d      = prio_q;

        if (accept0) begin
            m_address_d = req0.m_address;
            m_data_d    = req0.m_data;
            m_write_d   = req0.m_write;
            m_valid_d   = 1'b1;
            prio_d      = 1'b1;
        end else if (accept1) begin
            m_address_d = req1.m_address;
            m_data_d    = req1.m_data;
            m_write_d   = req1.m_write;
            m_valid_d   = 1'b1;
            prio_d      = 1'b0;
        end else if (slot) begin
            m_valid_d   = 1'b0;
        end

        // Only loads get a tag; the push test already used the pre-pop count.
        push     = (accept0 && !req0.m_write) || (accept1 && !req1.m_write);
        push_id  = accept1;
        pop      = mem.s_valid && mem.s_ready && tags_pending;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // A response with nothing outstanding is dropped and flagged until reset.
        err_d    = err_q || (mem.s_valid && !tags_pending);
    end

    // Tag storage: record the requester id of each accepted load.
    // NOTE: the tag array has no reset; count_q and the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= push_id;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values together.
        if (!rst_n) begin
            m_address_q <= '0;
            m_data_q    <= '0;
            m_write_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            prio_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            m_address_q <= m_address_d;
            m_data_q    <= m_data_d;
            m_write_q   <= m_write_d;
            m_valid_q   <= m_valid_d;
            prio_q      <= prio_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

endmodule
